// File: rtl/decode_stage.sv
// decode_stage: splits an instruction into op/mode/src/dst/literal and derives branch/store/writeback flags.
// Latency: 1 cycle from accept to out_valid; full throughput when no hazard and out_ready is held high.
// Backpressure: in_ready drops on flush, on a RAW/WAW scoreboard hazard, or when a held output is not consumed.
module decode_stage #(
   parameter int OP_W    = 5,
   parameter int MODE_W  = 2,
   parameter int REG_W   = 5,
   parameter int LIT_W   = 32,
   parameter int INSTR_W = OP_W + MODE_W + 2*REG_W + LIT_W,
   parameter logic [OP_W-1:0]   ST_OP    = 5'h02,
   parameter logic [OP_W-1:0]   BR_OP0   = 5'h10,
   parameter logic [OP_W-1:0]   BR_OP1   = 5'h11,
   parameter logic [OP_W-1:0]   BR_OP2   = 5'h12,
   parameter logic [MODE_W-1:0] REG_MODE = 2'b00
) (
   input  logic               clk,
   input  logic               rst,
   // fetch side
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   // execute side
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_W-1:0]    op,
   output logic [MODE_W-1:0]  mode,
   output logic [REG_W-1:0]   src,
   output logic [REG_W-1:0]   dst,
   output logic [LIT_W-1:0]   litsrc,
   output logic               branch,
   output logic               store,
   output logic               writeback,
   // control
   input  logic               flush,
   input  logic               wb_valid,
   input  logic [REG_W-1:0]   wb_reg,
   output logic [15:0]        stall_count
);

   localparam int NREG = 2**REG_W;

   // fields of the incoming instruction, MSB first: op, mode, src, dst, literal
   logic [OP_W-1:0]   in_op;
   logic [MODE_W-1:0] in_mode;
   logic [REG_W-1:0]  in_src;
   logic [REG_W-1:0]  in_dst;
   logic [LIT_W-1:0]  in_lit;
   logic              in_branch;
   logic              in_store;
   logic              in_wb;

   // scoreboard: one bit per GPR with a write issued but not yet written back
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   set_mask;
   logic [NREG-1:0]   clr_mask;

   logic              hazard;
   logic              accept;
   logic              issue;

   assign in_op   = instruction[INSTR_W-1 -: OP_W];
   assign in_mode = instruction[INSTR_W-OP_W-1 -: MODE_W];
   assign in_src  = instruction[INSTR_W-OP_W-MODE_W-1 -: REG_W];
   assign in_dst  = instruction[LIT_W+REG_W-1 -: REG_W];
   assign in_lit  = instruction[LIT_W-1:0];

   // classify the incoming opcode; anything that is neither branch nor store writes a GPR
   always_comb begin
      in_branch = 1'b0;
      in_store  = 1'b0;
      in_wb     = 1'b0;
      if (in_op == BR_OP0 || in_op == BR_OP1 || in_op == BR_OP2) begin
         in_branch = 1'b1;
      end
      if (in_op == ST_OP) begin
         in_store = 1'b1;
      end
      in_wb = !in_branch && !in_store;
   end

   // a register is busy if pending, or if the held output instruction is about to write it;
   // only registered state is used, so a writeback in this cycle does not unblock until next cycle
   always_comb begin
      busy = pending;
      if (out_valid && writeback) begin
         busy[dst] = 1'b1;
      end
   end

   // RAW on a register-mode source, WAW on the destination of a writing instruction;
   // branches and stores do not write, so their dst is never checked
   always_comb begin
      hazard = 1'b0;
      if (in_valid) begin
         if (in_mode == REG_MODE && busy[in_src]) begin
            hazard = 1'b1;
         end
         if (in_wb && busy[in_dst]) begin
            hazard = 1'b1;
         end
      end
   end

   assign in_ready = !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   // a flushed instruction is dropped, so it never reaches the scoreboard
   assign issue    = out_valid && out_ready && !flush && writeback;

   // scoreboard set/clear masks; set is applied after clear so a same-cycle collision ends set
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue) begin
         set_mask[dst] = 1'b1;
      end
      if (wb_valid) begin
         clr_mask[wb_reg] = 1'b1;
      end
   end

   // scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   // output register: load on accept, otherwise drop valid when consumed or flushed;
   // fields keep their last value when valid drops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         op        <= '0;
         mode      <= '0;
         src       <= '0;
         dst       <= '0;
         litsrc    <= '0;
         branch    <= 1'b0;
         store     <= 1'b0;
         writeback <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         op        <= in_op;
         mode      <= in_mode;
         src       <= in_src;
         dst       <= in_dst;
         litsrc    <= in_lit;
         branch    <= in_branch;
         store     <= in_store;
         writeback <= in_wb;
      end else if (out_ready || flush) begin
         out_valid <= 1'b0;
      end
   end

   // saturating count of cycles an instruction was held off by a scoreboard hazard
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (in_valid && hazard && !flush && stall_count != 16'hFFFF) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule
